// File: rtl/div_pkg.sv
// div_pkg: shared constants and FSM encoding for the iterative divider.
package div_pkg;

    localparam int DIV_W = 32;
    localparam int CNT_W = $clog2(DIV_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH+1:0] sh;
    logic [WIDTH+1:0] trial;

    // The extra top bit makes the trial subtraction's sign bit a clean borrow flag.
    assign sh    = {rem_i, quo_i[WIDTH-1]};
    assign trial = sh - {2'b00, dvs_i};
    assign rem_o = trial[WIDTH+1] ? sh[WIDTH:0] : trial[WIDTH:0];
    assign quo_o = {quo_i[WIDTH-2:0], ~trial[WIDTH+1]};

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative signed/unsigned restoring divider, one quotient bit per clock.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d, dvs_q, dvd_q, q_q, r_q;
    logic             q_neg_q, r_neg_q, busy_q, done_q, dz_q;
    logic [WIDTH-1:0] dvd_abs, dvs_abs, q_fin, r_fin, rem_lo;
    logic             zero, last;

    assign dvd_abs = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dvs_abs = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;
    assign zero    = (dvs_q == '0);
    assign last    = (cnt_q == CW'(WIDTH - 1));
    assign rem_lo  = rem_d[WIDTH-1:0];
    // A zero divisor bypasses sign correction and returns the raw dividend.
    assign q_fin   = zero ? '1    : (q_neg_q ? -quo_d  : quo_d);
    assign r_fin   = zero ? dvd_q : (r_neg_q ? -rem_lo : rem_lo);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_BUSY;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        rem_q   <= '0;
                        quo_q   <= dvd_abs;
                        dvs_q   <= dvs_abs;
                        dvd_q   <= dividend;
                        q_neg_q <= sign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_q <= sign && dividend[WIDTH-1];
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        q_q     <= q_fin;
                        r_q     <= r_fin;
                        dz_q    <= zero;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign q        = q_q;
    assign r        = r_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed-vector self-checking bench for div_unit.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sign = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] q, r;
    logic        busy, done, div_zero;
    int          n_chk = 0;
    int          n_fail = 0;
    int          e, b;

    div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sign     (sign),
        .dividend (dividend),
        .divisor  (divisor),
        .q        (q),
        .r        (r),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        sign = s;
        dividend = a;
        divisor = d;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges until done and busy-high samples, bounded at 100 edges.
    task automatic wait_done(output int edges, output int busy_n);
        edges = 0;
        busy_n = busy ? 1 : 0;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) busy_n++;
        end
    endtask

    task automatic do_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz);
        int ed, bn;
        launch(s, a, d);
        wait_done(ed, bn);
        check({tag, "_lat"}, ed, 32);
        check({tag, "_busy"}, bn, 32);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_q"}, q, eq);
        check({tag, "_r"}, r, er);
        check({tag, "_dz"}, div_zero, edz);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, done, 1'b0);
        check({tag, "_hold_q"}, q, eq);
    endtask

    initial begin
        #12;
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("u100_7", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0);
        do_op("sm7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        do_op("s7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0);
        do_op("sm100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        do_op("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0);
        do_op("u_big", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        do_op("u_ff_16", 1'b0, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 1'b0);
        do_op("dz5", 1'b1, 32'd5, 32'd0, 32'hFFFFFFFF, 32'h00000005, 1'b1);
        do_op("dzm5", 1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1);
        do_op("u9_3", 1'b0, 32'd9, 32'd3, 32'h00000003, 32'h00000000, 1'b0);

        // start while busy must be ignored
        launch(1'b0, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        sign = 1'b1;
        dividend = 32'd50;
        divisor = 32'd5;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(e, b);
        check("ign_lat", e, 27);
        check("ign_q", q, 32'd14);
        check("ign_r", r, 32'd2);
        repeat (3) @(posedge clk);
        #1;
        check("ign_noq", busy, 1'b0);

        // back-to-back: start in the done cycle
        launch(1'b0, 32'd1000, 32'd10);
        wait_done(e, b);
        check("b2b1_q", q, 32'd100);
        check("b2b1_r", r, 32'd0);
        sign = 1'b0;
        dividend = 32'd77;
        divisor = 32'd8;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_busy", busy, 1'b1);
        check("b2b_done", done, 1'b0);
        check("b2b_hold", q, 32'd100);
        wait_done(e, b);
        check("b2b2_lat", e, 32);
        check("b2b2_q", q, 32'd9);
        check("b2b2_r", r, 32'd5);

        // asynchronous reset mid-operation
        launch(1'b0, 32'd20, 32'd3);
        repeat (9) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_q", q, 32'd0);
        check("arst_r", r, 32'd0);
        check("arst_dz", div_zero, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("arst_idle", busy, 1'b0);
        check("arst_q2", q, 32'd0);

        do_op("u20_6", 1'b0, 32'd20, 32'd6, 32'h00000003, 32'h00000002, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit integer divider for the CPU datapath; executes MIPS DIV and DIVU, which the combinational ALU does not cover.
- The control unit drives operands with a start pulse and stalls on busy.
- The quotient (LO) and remainder (HI) are captured when done pulses.
- Restoring algorithm, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- dividend  input  WIDTH  numerator; sampled with start
- divisor  input  WIDTH  denominator; sampled with start
- q  output  WIDTH  quotient (to LO); registered
- r  output  WIDTH  remainder (to HI); registered
- busy  output  1  high while iterating
- done  output  1  single-cycle pulse; q/r valid from this cycle on
- div_zero  output  1  divisor was zero for the last completed op; registered with q/r

Behaviour:
- Reset (async, rst_n=0): state=IDLE; q=0, r=0, busy=0, done=0, div_zero=0; internal counter, shift and sign registers cleared.
- Reset mid-operation aborts the division; q/r read 0 after release.
- States:
  - IDLE: start=1 -> BUSY.
  - BUSY: counter 0..WIDTH-1, one bit per cycle; after the WIDTH-th iteration -> DONE.
  - DONE: one cycle; done=1; start=1 here -> BUSY (back-to-back accepted), else -> IDLE.
- Latency: start sampled at edge t; busy=1 for cycles t+1..t+WIDTH (exactly WIDTH cycles); done=1 in cycle t+WIDTH+1; q/r/div_zero update on that same edge.
- Outputs hold q/r/div_zero until the next completion; they do not change while busy.
- start while busy=1: ignored, no queuing; operand changes during BUSY have no effect.
- Operand capture at start:
  - If sign=1, latch |dividend| and |divisor| (two's-complement negate when MSB=1).
  - Latch the result signs: q_neg = dividend[31]^divisor[31]; r_neg = dividend[31].
- Iteration:
  - Remainder register is WIDTH+1 bits; shift {rem, quo} left 1; trial = rem - divisor_abs.
  - If trial is non-negative: rem=trial, quo[0]=1; else quo[0]=0.
- Completion:
  - Signed ops: negate the quotient if q_neg and the remainder if r_neg.
  - Quotient truncates toward zero; remainder sign follows the dividend.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: |a| = 0x80000000, giving q=0x80000000, r=0 (natural truncation, no trap).
- Divide by zero (divisor=0, either mode):
  - Full WIDTH latency still applies.
  - Result is forced to q=all ones, r=dividend (original, unnegated); div_zero=1.
  - The sign correction is not applied to this forced result.
- div_zero=0 for every non-zero divisor completion.
- Unsigned mode: no abs/negate; full 32-bit unsigned range.

Decomposition:
- Shared CPU package/header holds:
  - state encoding constants: S_IDLE=2'd0, S_BUSY=2'd1, S_DONE=2'd2
  - DIV_W = 32
  - iteration counter width: clog2(WIDTH)=5 bits, sized to count to WIDTH-1
- One natural sub-module, div_step:
  - combinational single restoring iteration
  - inputs: rem, quo, divisor_abs
  - outputs: next rem, next quo
- FSM, sign handling and output registers stay in div_unit.

Test Plan:
- Unsigned 100 / 7, sign=0, start at edge t -> busy for 32 cycles; done at t+33; q=0x0000000E, r=0x00000002, div_zero=0.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002), sign=1 -> q=0xFFFFFFFD, r=0xFFFFFFFF.
- Signed 7 / -2 -> q=0xFFFFFFFD, r=0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.
- Unsigned 0xFFFFFFFF / 0x00000010 -> q=0x0FFFFFFF, r=0xF.
- Divide by zero, 5 / 0, sign=1 -> after 33 cycles q=0xFFFFFFFF, r=0x00000005, div_zero=1.
- Next op 9 / 3 -> div_zero returns to 0; q=3, r=0.
- Handshake:
  - Pulse start again at t+5 with different operands -> ignored; result matches the first op.
  - Assert start in the done cycle -> busy rises next cycle; second result appears 33 cycles later.
- Reset: assert rst_n=0 at t+10 of an op, asynchronously between edges -> busy, done, q, r and div_zero drop to 0 immediately.
- After reset release a new op 20 / 6 completes normally with q=3, r=2.
